iter_divider: RTL and testbench
===============================

Name: iter_divider

Overview:
- Multi-cycle radix-2 restoring divider: the subtractive counterpart of the combinational 32-bit adder datapath.
- Computes quotient and remainder for the RV32M DIV/DIVU/REM/REMU semantics, one quotient bit per cycle.
- Sits beside the ALU in the EXU and is driven through a valid/ready request/response handshake.
- Internal subtraction of the shifted remainder and divisor is a DATA_WIDTH+1-bit subtract with a borrow test.

Parameters:
DATA_WIDTH, 32, operand/result width in bits; must be at least 4.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  abort any operation in flight; synchronous
in_valid  input  1  request valid
in_ready  output  1  divider can accept a request
is_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
dividend  input  DATA_WIDTH  dividend operand
divisor  input  DATA_WIDTH  divisor operand
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  DATA_WIDTH  quotient
remainder  output  DATA_WIDTH  remainder
div_by_zero  output  1  result came from a zero divisor
overflow  output  1  result came from signed MIN / -1

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_by_zero=0; overflow=0.
- Control priority: rst > flush > normal operation.
- States:
  - IDLE: in_ready=1.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: handshake completes on the edge where in_valid && in_ready.
  - Latch the absolute values of the operands (two's-complement negate when is_signed and MSB=1).
  - Record the quotient sign (operand signs differ) and the remainder sign (dividend sign).
  - Clear the iteration counter.
- Special cases, decided at accept; go IDLE -> DONE directly, so out_valid=1 on the cycle after accept:
  - divisor==0: quotient = all ones; remainder = dividend (unmodified); div_by_zero=1. Applies to both signed and unsigned.
  - is_signed, dividend=MIN, divisor=all ones: quotient=MIN; remainder=0; overflow=1.
- Normal path: IDLE -> CALC. Each CALC cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem.
  - If no borrow, keep the difference and set the quotient LSB to 1; otherwise restore rem and set it to 0.
  - After DATA_WIDTH iterations, go to DONE. The counter wraps 0..DATA_WIDTH-1.
- On the CALC -> DONE edge, apply the sign fix:
  - Negate the quotient if its sign flag is set.
  - Negate the remainder if the dividend was negative.
  - div_by_zero=0, overflow=0.
- Latency: out_valid rises exactly DATA_WIDTH+1 cycles after the accept edge (33 at default).
- DONE: all outputs held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE; out_valid=0 on the next cycle.
  - No new accept in the same cycle; minimum issue interval is DATA_WIDTH+2 cycles.
- quotient and remainder keep the last result in IDLE; they are only meaningful while out_valid=1.
- flush in any state: next cycle state=IDLE, out_valid=0, in_ready=1, flags cleared.
  - flush wins over a simultaneous in_valid handshake: the request is dropped.
- in_valid in CALC/DONE is ignored (in_ready=0); the requester must hold the request.

Optional Feature:
- Macro: ITER_DIVIDER_PERF_CNT_EN.
- Defined:
  - Extra output busy_cycles (32 bits): counts every cycle with state != IDLE.
  - Saturates at all ones.
  - Cleared by rst only, not by flush.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Unsigned 100 / 7: accept at cycle 0 -> out_valid at cycle 33; quotient=14, remainder=2, flags 0; in_ready=1 the cycle after out_ready handshake.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
- Divide by zero: 5 / 0, both is_signed values -> out_valid on the cycle after accept; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF, is_signed=1 -> one-cycle result; quotient=0x80000000, remainder=0, overflow=1. The same operands with is_signed=0 -> normal path, quotient=0, remainder=0x80000000 at cycle 33.
- Backpressure: 0xFFFFFFFF / 0x10 unsigned with out_ready=0 for 5 cycles after out_valid -> quotient=0x0FFFFFFF and remainder=0xF held stable, in_ready=0; release -> IDLE.
- Flush and reset mid-operation: flush at the 10th CALC cycle -> next cycle in_ready=1, out_valid=0; a new 9 / 3 request completes correctly (quotient=3, remainder=0). rst asserted in CALC -> all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle with a valid/ready request/response handshake.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   flush         abort any operation in flight (request in the same cycle is dropped)
//   in_valid/in_ready     request handshake; is_signed, dividend, divisor are operands
//   out_valid/out_ready   response handshake; quotient, remainder are the result
//   div_by_zero   result came from a zero divisor
//   overflow      result came from signed MIN / -1
//   busy_cycles   (only with ITER_DIVIDER_PERF_CNT_EN) saturating count of non-IDLE cycles
//
// Optional feature macro: ITER_DIVIDER_PERF_CNT_EN
module iter_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero,
    output logic                  overflow
`ifdef ITER_DIVIDER_PERF_CNT_EN
    ,
    output logic [31:0]           busy_cycles
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    // Magnitude of a signed operand; unsigned operands pass through untouched.
    function automatic logic [DATA_WIDTH-1:0] abs_val(input logic signed [DATA_WIDTH-1:0] v,
                                                      input logic en);
        return (en && (v < 0)) ? negate(v) : v;
    endfunction

    state_t                  state_q;
    logic                    in_ready_q, out_valid_q, dbz_q, ovf_q;
    logic                    q_neg_q, r_neg_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   rem_q, quo_q, dvs_q;

    logic [DATA_WIDTH:0]     trial_d;
    logic                    borrow_d;
    logic [DATA_WIDTH-1:0]   rem_d, quo_d;
    logic                    zero_div_d, ovf_case_d;

    // One restoring step: {rem,quo} << 1, then a DATA_WIDTH+1-bit trial subtract.
    // Since rem < divisor, the top bit of the difference is exactly the borrow.
    always_comb begin
        trial_d    = {rem_q, quo_q[DATA_WIDTH-1]} - {1'b0, dvs_q};
        borrow_d   = trial_d[DATA_WIDTH];
        rem_d      = borrow_d ? {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]}
                              : trial_d[DATA_WIDTH-1:0];
        quo_d      = {quo_q[DATA_WIDTH-2:0], ~borrow_d};
        zero_div_d = (divisor == '0);
        ovf_case_d = is_signed && (dividend == MIN_VAL) && (divisor == ALL_ONES);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        cnt_q      <= '0;
                        q_neg_q    <= is_signed && (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
                        r_neg_q    <= is_signed && dividend[DATA_WIDTH-1];
                        dvs_q      <= abs_val(divisor, is_signed);
                        dbz_q      <= 1'b0;
                        ovf_q      <= 1'b0;
                        if (zero_div_d) begin
                            quo_q       <= ALL_ONES;
                            rem_q       <= dividend;
                            dbz_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (ovf_case_d) begin
                            quo_q       <= MIN_VAL;
                            rem_q       <= '0;
                            ovf_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            quo_q   <= abs_val(dividend, is_signed);
                            rem_q   <= '0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cnt_q == CNT_W'(DATA_WIDTH-1)) begin
                        // Last iteration: fold the sign fix into the final write.
                        cnt_q       <= '0;
                        quo_q       <= q_neg_q ? negate(quo_d) : quo_d;
                        rem_q       <= r_neg_q ? negate(rem_d) : rem_d;
                        dbz_q       <= 1'b0;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

`ifdef ITER_DIVIDER_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] busy_q;

    // Survives flush on purpose: only rst clears the statistic.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else if (state_q != IDLE) begin
            busy_q <= sat_inc(busy_q);
        end
    end

    assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_iter_divider.sv
module tb_iter_divider;

    localparam int W = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, is_signed;
    logic [31:0] dividend, divisor, quotient, remainder;
    logic        out_valid, out_ready, div_by_zero, overflow;
`ifdef ITER_DIVIDER_PERF_CNT_EN
    logic [31:0] busy_cycles;
`endif

    iter_divider #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
`ifdef ITER_DIVIDER_PERF_CNT_EN
        , .busy_cycles(busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
        int          acc;
        bit          seen;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Reference: RV32M division rules in plain integer arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output exp_t e);
        longint sa, sb, qq, rr;
        e.dz = 1'b0; e.ov = 1'b0; e.seen = 0; e.acc = 0;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else if (s && a == MINV && b == 32'hFFFF_FFFF) begin
            e.q = MINV; e.r = 32'd0; e.ov = 1'b1; e.lat = 1;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            qq = sa / sb;
            rr = sa % sb;
            e.q = qq[31:0];
            e.r = rr[31:0];
            e.lat = W + 1;
        end
    endfunction

    // Compare process: every cycle a result is presented it must match the head of the model queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    if (!e.seen) begin
                        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                        exp_q[0].seen = 1;
                    end
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                    chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
                    chk("in_ready_while_valid", {31'd0, in_ready}, 32'd0);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        int n;
        bit ok;
        model(a, b, s, e);
        @(posedge clk);
        #2;
        in_valid = 1'b1; dividend = a; divisor = b; is_signed = s;
        n = 0; ok = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            n++;
        end
        if (!ok) begin
            chk("accept_timeout", 32'd1, 32'd0);
        end else begin
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk({nm, "_done_timeout"}, 32'd1, 32'd0);
            exp_q.delete();
        end else begin
            @(negedge clk);
            chk({nm, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
            chk({nm, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
        end
    endtask

    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int hold, input logic [31:0] lq,
                          input logic [31:0] lr, input logic ldz, input logic lov);
        exp_t m;
        int n;
        model(a, b, s, m);
        chk({nm, "_model_q"}, m.q, lq);
        chk({nm, "_model_r"}, m.r, lr);
        chk({nm, "_model_dz"}, {31'd0, m.dz}, {31'd0, ldz});
        chk({nm, "_model_ov"}, {31'd0, m.ov}, {31'd0, lov});
        out_ready = (hold == 0);
        send(a, b, s);
        if (hold > 0) begin
            n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!out_valid) chk({nm, "_valid_timeout"}, 32'd1, 32'd0);
            repeat (hold) @(negedge clk);
            @(posedge clk);
            #2;
            out_ready = 1'b1;
        end
        wait_done(nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        run_op("u100_7",   32'd100,       32'd7,         1'b0, 0, 32'd14,        32'd2,         1'b0, 1'b0);
        run_op("s_m7_2",   32'hFFFF_FFF9, 32'd2,         1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("s_7_m2",   32'd7,         32'hFFFF_FFFE, 1'b1, 0, 32'hFFFF_FFFD, 32'd1,         1'b0, 1'b0);
        run_op("s_m100_m7",32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 0, 32'd14,        32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("u_small",  32'd3,         32'd10,        1'b0, 0, 32'd0,         32'd3,         1'b0, 1'b0);
        run_op("u_by1",    32'hFFFF_FFFF, 32'd1,         1'b0, 0, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0);
        run_op("dz_u",     32'd5,         32'd0,         1'b0, 0, 32'hFFFF_FFFF, 32'd5,         1'b1, 1'b0);
        run_op("dz_s",     32'd5,         32'd0,         1'b1, 0, 32'hFFFF_FFFF, 32'd5,         1'b1, 1'b0);
        run_op("dz_s_min", MINV,          32'd0,         1'b1, 0, 32'hFFFF_FFFF, MINV,          1'b1, 1'b0);
        run_op("ovf_s",    MINV,          32'hFFFF_FFFF, 1'b1, 0, MINV,          32'd0,         1'b0, 1'b1);
        run_op("ovf_u",    MINV,          32'hFFFF_FFFF, 1'b0, 0, 32'd0,         MINV,          1'b0, 1'b0);
        run_op("bp",       32'hFFFF_FFFF, 32'h10,        1'b0, 5, 32'h0FFF_FFFF, 32'hF,         1'b0, 1'b0);
        run_op("bp_dz",    32'd77,        32'd0,         1'b0, 3, 32'hFFFF_FFFF, 32'd77,        1'b1, 1'b0);

        // Flush during the 10th CALC cycle; the result must never appear.
        out_ready = 1'b1;
        send(32'hDEAD_BEEF, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        flush = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #2;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        run_op("after_flush", 32'd9, 32'd3, 1'b0, 0, 32'd3, 32'd0, 1'b0, 1'b0);

        // flush beats a simultaneous request: nothing may be accepted.
        @(posedge clk);
        #2;
        flush = 1'b1; in_valid = 1'b1; dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0;
        @(posedge clk);
        #2;
        flush = 1'b0; in_valid = 1'b0;
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || !in_ready) nv++;
        end
        chk("flush_drops_request", 32'(nv), 32'd0);

        // Reset in the middle of CALC.
        send(32'd1000, 32'd3, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        chk("midrst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        run_op("after_rst", 32'd1000, 32'd3, 1'b0, 0, 32'd333, 32'd1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
